// File: rtl/game_pkg.sv
// Shared types and constants for the shape-guessing game.
package game_pkg;

  localparam int unsigned NUM_SLOTS  = 4;
  localparam int unsigned SHAPE_W    = 3;
  localparam int unsigned ZNARLY_W   = 3;
  localparam logic [ZNARLY_W-1:0] ZNARLY_WIN = 3'd4;

  // Encoding doubles as the debug/HEX state code.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GRADE = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } seq_state_t;

endpackage

// File: rtl/up_counter.sv
// Up counter with synchronous active-low reset, synchronous clear and enable.
module up_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + W'(1);
  end

endmodule

// File: rtl/game_sequencer.sv
// Round controller: clears/gates the master loader, sequences guesses
// through the grader with timeout retry, and decides win or loss.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS    = 8,
  parameter int unsigned ROUND_W       = 4,
  parameter int unsigned GRADE_TIMEOUT = 255
) (
  input  logic               CLOCK_50,
  input  logic               reset_N,
  input  logic               startGame,
  input  logic               masterLoaded,
  input  logic               guessSubmit,
  input  logic               gradeDone,
  input  logic [2:0]         znarly,
  output logic               gamePlaying,
  output logic               resetMaster,
  output logic               gradeStart,
  output logic [ROUND_W-1:0] roundNum,
  output logic               gameWon,
  output logic               gameLost,
  output logic               gradeErr,
  output logic [2:0]         stateOut
);

  localparam int unsigned TMO_W = $clog2(GRADE_TIMEOUT + 1);

  seq_state_t       state, state_nx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             round_clr, round_en, tmo_clr, tmo_en;
  logic             round_last, grade_win, grade_bad, tmo_hit, tmo_wrap;
  logic             playing_nx, reset_master_nx, grade_start_nx;
  logic             won_nx, lost_nx, grade_err_nx;

  assign round_last = (roundNum == ROUND_W'(MAX_ROUNDS));
  assign grade_win  = (znarly == ZNARLY_WIN);
  assign grade_bad  = (znarly > ZNARLY_WIN);
  // Retry is decided one cycle early so the registered pulse lands on the wrap cycle.
  assign tmo_hit    = (tmo_cnt == TMO_W'(GRADE_TIMEOUT - 1));
  assign tmo_wrap   = (tmo_cnt == TMO_W'(GRADE_TIMEOUT));

  assign tmo_clr  = (state != S_GRADE) || tmo_wrap;
  assign tmo_en   = (state == S_GRADE) && !gradeDone;
  assign stateOut = 3'(state);

  up_counter #(.W(ROUND_W)) u_round (
    .clk   (CLOCK_50),
    .rst_n (reset_N),
    .clr   (round_clr),
    .en    (round_en),
    .q     (roundNum)
  );

  up_counter #(.W(TMO_W)) u_timeout (
    .clk   (CLOCK_50),
    .rst_n (reset_N),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .q     (tmo_cnt)
  );

  // State and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_N) begin
      state       <= S_IDLE;
      gamePlaying <= 1'b0;
      resetMaster <= 1'b0;
      gradeStart  <= 1'b0;
      gameWon     <= 1'b0;
      gameLost    <= 1'b0;
      gradeErr    <= 1'b0;
    end else begin
      state       <= state_nx;
      gamePlaying <= playing_nx;
      resetMaster <= reset_master_nx;
      gradeStart  <= grade_start_nx;
      gameWon     <= won_nx;
      gameLost    <= lost_nx;
      gradeErr    <= grade_err_nx;
    end
  end

  // Next-state, counter control and next output values.
  always_comb begin
    state_nx        = state;
    round_clr       = 1'b0;
    round_en        = 1'b0;
    grade_start_nx  = 1'b0;
    grade_err_nx    = gradeErr;
    playing_nx      = 1'b0;
    reset_master_nx = 1'b0;
    won_nx          = 1'b0;
    lost_nx         = 1'b0;

    case (state)
      S_IDLE: if (startGame) state_nx = S_CLEAR;
      S_CLEAR: begin
        round_clr    = 1'b1;
        grade_err_nx = 1'b0;
        state_nx     = S_LOAD;
      end
      S_LOAD: if (masterLoaded) begin
        state_nx = S_PLAY;
        round_en = 1'b1;
      end
      S_PLAY: if (guessSubmit) begin
        state_nx       = S_GRADE;
        grade_start_nx = 1'b1;
      end
      S_GRADE: begin
        if (gradeDone) begin
          if (grade_bad) grade_err_nx = 1'b1;
          if (grade_win)       state_nx = S_WIN;
          else if (round_last) state_nx = S_LOSE;
          else begin
            state_nx = S_PLAY;
            round_en = 1'b1;
          end
        end else if (tmo_hit) begin
          grade_start_nx = 1'b1;
        end
      end
      S_WIN, S_LOSE: if (startGame) state_nx = S_CLEAR;
      default: state_nx = S_IDLE;
    endcase

    playing_nx      = (state_nx == S_PLAY) || (state_nx == S_GRADE);
    reset_master_nx = (state_nx == S_CLEAR);
    won_nx          = (state_nx == S_WIN);
    lost_nx         = (state_nx == S_LOSE);
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench: stimulus queues expected output events, a monitor checks them.
module tb_game_sequencer;

  localparam int unsigned ROUND_W = 4;

  logic               CLOCK_50 = 1'b0;
  logic               reset_N, startGame, masterLoaded, guessSubmit, gradeDone;
  logic [2:0]         znarly;
  logic               gamePlaying, resetMaster, gradeStart, gameWon, gameLost, gradeErr;
  logic [ROUND_W-1:0] roundNum;
  logic [2:0]         stateOut;

  game_sequencer #(.MAX_ROUNDS(8), .ROUND_W(ROUND_W), .GRADE_TIMEOUT(4)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset_N      (reset_N),
    .startGame    (startGame),
    .masterLoaded (masterLoaded),
    .guessSubmit  (guessSubmit),
    .gradeDone    (gradeDone),
    .znarly       (znarly),
    .gamePlaying  (gamePlaying),
    .resetMaster  (resetMaster),
    .gradeStart   (gradeStart),
    .roundNum     (roundNum),
    .gameWon      (gameWon),
    .gameLost     (gameLost),
    .gradeErr     (gradeErr),
    .stateOut     (stateOut)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, LOAD = 3'd2, PLAY = 3'd3,
                         GRADE = 3'd4, WIN = 3'd5, LOSE = 3'd6;

  typedef struct {
    string      name;
    int         cyc;
    logic [2:0] st;
    logic [3:0] rn;
    logic       gp, gw, gl, ge, rm, gs;
  } ev_t;

  ev_t        sb[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic       mon_en = 1'b0;
  logic [2:0] prev_st = 3'd7;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Monitor: every state change or strobe is an output event to be checked.
  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      if (stateOut !== prev_st || gradeStart === 1'b1 || resetMaster === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: cyc=%0d st=%0d rn=%0d gs=%0b rm=%0b, required no event",
                   cyc, stateOut, roundNum, gradeStart, resetMaster);
        end else begin
          ev_t e;
          e = sb.pop_front();
          if (e.cyc !== cyc || e.st !== stateOut || e.rn !== roundNum || e.gp !== gamePlaying ||
              e.gw !== gameWon || e.gl !== gameLost || e.ge !== gradeErr ||
              e.rm !== resetMaster || e.gs !== gradeStart) begin
            miscompares++;
            $display("FAIL %s: got cyc=%0d st=%0d rn=%0d gp=%0b gw=%0b gl=%0b ge=%0b rm=%0b gs=%0b; required cyc=%0d st=%0d rn=%0d gp=%0b gw=%0b gl=%0b ge=%0b rm=%0b gs=%0b",
                     e.name, cyc, stateOut, roundNum, gamePlaying, gameWon, gameLost, gradeErr,
                     resetMaster, gradeStart, e.cyc, e.st, e.rn, e.gp, e.gw, e.gl, e.ge, e.rm, e.gs);
          end
        end
      end
      prev_st = stateOut;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic expect_ev(input string name, input int d, input logic [2:0] st,
                           input logic [3:0] rn, input logic ge, input logic rm, input logic gs);
    ev_t e;
    e.name = name;
    e.cyc  = cyc + d;
    e.st   = st;
    e.rn   = rn;
    e.gp   = (st == PLAY) || (st == GRADE);
    e.gw   = (st == WIN);
    e.gl   = (st == LOSE);
    e.ge   = ge;
    e.rm   = rm;
    e.gs   = gs;
    sb.push_back(e);
  endtask

  task automatic start_game(input string name, input logic [3:0] rn_prev, input logic ge_prev);
    startGame = 1'b1;
    expect_ev({name, "_clear"}, 1, CLEAR, rn_prev, ge_prev, 1'b1, 1'b0);
    expect_ev({name, "_load"},  2, LOAD,  4'd0,    1'b0,    1'b0, 1'b0);
    tick(1);
    startGame = 1'b0;
    tick(1);
  endtask

  // Holds LOAD for n cycles (poking the ignored startGame), then loads the master.
  task automatic load(input string name, input int n);
    if (n > 0) begin
      startGame = 1'b1;
      tick(1);
      startGame = 1'b0;
      tick(n - 1);
    end
    masterLoaded = 1'b1;
    expect_ev({name, "_play"}, 1, PLAY, 4'd1, 1'b0, 1'b0, 1'b0);
    tick(1);
    masterLoaded = 1'b0;
  endtask

  task automatic guess(input string name, input logic [3:0] rn, input logic ge);
    guessSubmit = 1'b1;
    expect_ev({name, "_gstart"}, 1, GRADE, rn, ge, 1'b0, 1'b1);
    tick(1);
    guessSubmit = 1'b0;
  endtask

  task automatic grade(input string name, input logic [2:0] z, input int w,
                       input logic [2:0] st, input logic [3:0] rn, input logic ge);
    tick(w);
    gradeDone = 1'b1;
    znarly    = z;
    expect_ev({name, "_result"}, 1, st, rn, ge, 1'b0, 1'b0);
    tick(1);
    gradeDone = 1'b0;
    znarly    = 3'd0;
  endtask

  initial begin
    reset_N = 1'b0; startGame = 1'b0; masterLoaded = 1'b0;
    guessSubmit = 1'b0; gradeDone = 1'b0; znarly = 3'd0;
    tick(2);
    expect_ev("por", 0, IDLE, 4'd0, 1'b0, 1'b0, 1'b0);
    mon_en  = 1'b1;
    reset_N = 1'b1;
    tick(2);

    // Win on the third guess.
    start_game("g1", 4'd0, 1'b0);
    load("g1", 3);
    guess("w1", 4'd1, 1'b0); grade("w1", 3'd2, 1, PLAY, 4'd2, 1'b0);
    guess("w2", 4'd2, 1'b0); grade("w2", 3'd1, 0, PLAY, 4'd3, 1'b0);
    guess("w3", 4'd3, 1'b0); grade("w3", 3'd4, 2, WIN,  4'd3, 1'b0);
    tick(3);

    // Eight misses: lose at round 8 with no wrap.
    start_game("g2", 4'd3, 1'b0);
    load("g2", 0);
    for (int i = 1; i <= 8; i++) begin
      guess($sformatf("l%0d", i), 4'(i), 1'b0);
      if (i < 8) grade($sformatf("l%0d", i), 3'd0, 0, PLAY, 4'(i + 1), 1'b0);
      else       grade($sformatf("l%0d", i), 3'd0, 0, LOSE, 4'd8, 1'b0);
    end
    tick(3);

    // Ignored inputs, then a bad grade.
    start_game("g3", 4'd8, 1'b0);
    load("g3", 1);
    startGame = 1'b1; tick(1); startGame = 1'b0;
    gradeDone = 1'b1; znarly = 3'd4; tick(1); gradeDone = 1'b0; znarly = 3'd0;
    tick(1);
    guess("b1", 4'd1, 1'b0);
    guessSubmit = 1'b1; tick(1); guessSubmit = 1'b0;
    grade("bad", 3'd6, 0, PLAY, 4'd2, 1'b1);

    // Timeout retries at GRADE cycles 5 and 10; gradeDone on the next timeout suppresses the retry.
    guess("t1", 4'd2, 1'b1);
    expect_ev("retry1", 4, GRADE, 4'd2, 1'b1, 1'b0, 1'b1);
    expect_ev("retry2", 9, GRADE, 4'd2, 1'b1, 1'b0, 1'b1);
    grade("tmo", 3'd3, 13, PLAY, 4'd3, 1'b1);

    guess("t2", 4'd3, 1'b1); grade("t2", 3'd4, 0, WIN, 4'd3, 1'b1);
    tick(2);

    // New game clears gradeErr; then reset mid-GRADE.
    start_game("g4", 4'd3, 1'b1);
    load("g4", 0);
    guess("r1", 4'd1, 1'b0);
    tick(1);
    reset_N = 1'b0;
    expect_ev("mid_reset", 1, IDLE, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    reset_N = 1'b1;
    tick(2);
    start_game("g5", 4'd0, 1'b0);
    tick(3);

    while (sb.size() > 0) begin
      ev_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: got no event, required st=%0d at cyc=%0d", e.name, e.st, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required completion within 200000 time units");
    $fatal(1);
  end

endmodule
